// File: rtl/arcade_input_mapper.sv
// Player input front end: ps2 key state, joystick merge, rotation,
// autofire and stretched coin pulses, registered per player.
module arcade_input_mapper #(
  parameter int          NUM_BUTTONS   = 3,
  parameter logic [15:0] COIN_PULSE    = 16'd50000,
  parameter logic [19:0] AUTOFIRE_DIV  = 20'd200000,
  parameter bit          COIN_ON_START = 1'b1
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic [10:0]            ps2_key,
  input  logic [15:0]            joystick_0,
  input  logic [15:0]            joystick_1,
  input  logic [1:0]             rotate,
  input  logic [NUM_BUTTONS-1:0] autofire_en,
  output logic [3:0]             dir_p1,
  output logic [3:0]             dir_p2,
  output logic [NUM_BUTTONS-1:0] btn_p1,
  output logic [NUM_BUTTONS-1:0] btn_p2,
  output logic [1:0]             start,
  output logic [1:0]             coin
);

  localparam int NB = NUM_BUTTONS;

  logic r_old_toggle;
  logic r_k_up, r_k_dn, r_k_lf, r_k_rt;
  logic r_k_b0a, r_k_b0b, r_k_b1, r_k_b2;
  logic r_k_st1, r_k_st2, r_k_cn1, r_k_cn2;
  logic [19:0] r_af_cnt;
  logic r_af_phase;
  logic [1:0] r_prev_coin, r_prev_start;
  logic [15:0] r_coin_cnt [2];

  logic w_event, w_press;
  logic [9:0] w_kb_btn_ext;
  logic [NB-1:0] w_kb_btn, w_af_mask;
  logic [NB-1:0] w_raw1_btn, w_raw2_btn;
  logic [3:0] w_raw1_dir, w_raw2_dir;
  logic [1:0] w_raw_start, w_raw_coin, w_trig;
  logic w_unused;

  assign w_event = ps2_key[10] != r_old_toggle;
  assign w_press = ps2_key[9];
  assign w_unused = &{1'b0, joystick_0, joystick_1};

  // Held-key state tracks press/release events from the keyboard.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_old_toggle <= 1'b0;
      r_k_up  <= 1'b0;
      r_k_dn  <= 1'b0;
      r_k_lf  <= 1'b0;
      r_k_rt  <= 1'b0;
      r_k_b0a <= 1'b0;
      r_k_b0b <= 1'b0;
      r_k_b1  <= 1'b0;
      r_k_b2  <= 1'b0;
      r_k_st1 <= 1'b0;
      r_k_st2 <= 1'b0;
      r_k_cn1 <= 1'b0;
      r_k_cn2 <= 1'b0;
    end else begin
      r_old_toggle <= ps2_key[10];
      if (w_event) begin
        unique case (ps2_key[8:0])
          9'h075, 9'h175: r_k_up  <= w_press;
          9'h072, 9'h172: r_k_dn  <= w_press;
          9'h06B, 9'h16B: r_k_lf  <= w_press;
          9'h074, 9'h174: r_k_rt  <= w_press;
          9'h029:         r_k_b0a <= w_press;
          9'h014:         r_k_b0b <= w_press;
          9'h011:         r_k_b1  <= w_press;
          9'h012:         r_k_b2  <= w_press;
          9'h005:         r_k_st1 <= w_press;
          9'h006:         r_k_st2 <= w_press;
          9'h02E:         r_k_cn1 <= w_press;
          9'h036:         r_k_cn2 <= w_press;
          default: ;
        endcase
      end
    end
  end

  assign w_kb_btn_ext = {7'b0, r_k_b2, r_k_b1, r_k_b0a | r_k_b0b};
  assign w_kb_btn = w_kb_btn_ext[NB-1:0];

  assign w_raw1_dir = {r_k_up | joystick_0[3], r_k_dn | joystick_0[2],
                       r_k_lf | joystick_0[1], r_k_rt | joystick_0[0]};
  assign w_raw2_dir = joystick_1[3:0];
  assign w_raw1_btn = w_kb_btn | joystick_0[4 +: NB];
  assign w_raw2_btn = joystick_1[4 +: NB];
  assign w_raw_start = {r_k_st2 | joystick_1[4+NB], r_k_st1 | joystick_0[4+NB]};
  assign w_raw_coin  = {r_k_cn2 | joystick_1[5+NB], r_k_cn1 | joystick_0[5+NB]};

  assign w_af_mask = ~autofire_en | {NB{r_af_phase}};

  assign w_trig = (w_raw_coin & ~r_prev_coin) |
                  (COIN_ON_START ? (w_raw_start & ~r_prev_start) : 2'b00);

  // {U,D,L,R} raw -> {up,down,left,right} screen orientation.
  function automatic logic [3:0] f_rot(input logic [3:0] d, input logic [1:0] r);
    logic [3:0] o;
    o = d;
    case (r)
      2'd1: o = {d[1], d[0], d[2], d[3]};
      2'd2: o = {d[2], d[3], d[0], d[1]};
      2'd3: o = {d[0], d[1], d[3], d[2]};
      default: o = d;
    endcase
    return o;
  endfunction

  // Free-running autofire divider; phase flips on each wrap.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (r_af_cnt == AUTOFIRE_DIV - 20'd1) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + 20'd1;
    end
  end

  // Coin stretchers: load on edge when idle, count down otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_prev_coin  <= '0;
      r_prev_start <= '0;
      r_coin_cnt[0] <= '0;
      r_coin_cnt[1] <= '0;
    end else begin
      r_prev_coin  <= w_raw_coin;
      r_prev_start <= w_raw_start;
      for (int p = 0; p < 2; p++) begin
        if (r_coin_cnt[p] == 16'd0) begin
          if (w_trig[p]) r_coin_cnt[p] <= COIN_PULSE;
        end else begin
          r_coin_cnt[p] <= r_coin_cnt[p] - 16'd1;
        end
      end
    end
  end

  assign coin = {r_coin_cnt[1] != 16'd0, r_coin_cnt[0] != 16'd0};

  // Registered control vectors for the game core.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dir_p1 <= '0;
      dir_p2 <= '0;
      btn_p1 <= '0;
      btn_p2 <= '0;
      start  <= '0;
    end else begin
      dir_p1 <= f_rot(w_raw1_dir, rotate);
      dir_p2 <= f_rot(w_raw2_dir, rotate);
      btn_p1 <= w_raw1_btn & w_af_mask;
      btn_p2 <= w_raw2_btn & w_af_mask;
      start  <= w_raw_start;
    end
  end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Scoreboard bench for arcade_input_mapper: stimulus queues
// cycle-tagged expectations, a monitor checks them on negedge.
module tb_arcade_input_mapper;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic [1:0] rotate;
  logic [2:0] autofire_en;
  logic [3:0] dir_p1, dir_p2;
  logic [2:0] btn_p1, btn_p2;
  logic [1:0] start, coin;

  arcade_input_mapper #(
    .NUM_BUTTONS(3),
    .COIN_PULSE(16'd4),
    .AUTOFIRE_DIV(20'd3),
    .COIN_ON_START(1'b1)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .ps2_key(ps2_key),
    .joystick_0(joystick_0),
    .joystick_1(joystick_1),
    .rotate(rotate),
    .autofire_en(autofire_en),
    .dir_p1(dir_p1),
    .dir_p2(dir_p2),
    .btn_p1(btn_p1),
    .btn_p2(btn_p2),
    .start(start),
    .coin(coin)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    int cyc;
    int sel;
    logic [15:0] v;
    string nm;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int n_run = 0;
  int n_fail = 0;
  logic tg = 1'b0;
  event ev_now;

  always @(posedge clk_sys) cyc <= cyc + 1;

  function automatic logic [15:0] get(int sel);
    case (sel)
      0: return {12'b0, dir_p1};
      1: return {12'b0, dir_p2};
      2: return {13'b0, btn_p1};
      3: return {13'b0, btn_p2};
      4: return {14'b0, start};
      default: return {14'b0, coin};
    endcase
  endfunction

  task automatic scan(int c);
    logic [15:0] a;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].cyc == c) begin
        a = get(q[i].sel);
        n_run++;
        if (a !== q[i].v) begin
          n_fail++;
          $display("FAIL %s @cyc %0d: got %h, expected %h",
                   q[i].nm, cyc, a, q[i].v);
        end
        q.delete(i);
      end
    end
  endtask

  always @(negedge clk_sys) scan(cyc);
  always @(ev_now) scan(-1);

  task automatic step();
    @(negedge clk_sys);
    #1;
  endtask

  task automatic tick(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic expect_out(int d, int sel, logic [15:0] v, string nm);
    exp_t e;
    e.cyc = (d < 0) ? -1 : cyc + d;
    e.sel = sel;
    e.v = v;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic send(logic p, logic [8:0] code);
    tg = ~tg;
    ps2_key = {tg, p, code};
  endtask

  initial begin
    reset_n = 1'b0;
    ps2_key = '0;
    joystick_0 = 16'hFFFF;
    joystick_1 = '0;
    rotate = 2'd0;
    autofire_en = 3'b000;

    step();
    for (int s = 0; s < 6; s++) expect_out(1, s, 16'h0, "reset_zero");
    tick(2);
    reset_n = 1'b1;
    expect_out(1, 0, 16'hF, "release_dir");
    expect_out(1, 2, 16'h7, "release_btn");
    expect_out(1, 4, 16'h1, "release_start");
    for (int d = 1; d <= 4; d++) expect_out(d, 5, 16'h1, "release_coin_on");
    expect_out(5, 5, 16'h0, "release_coin_off");
    tick(6);
    joystick_0 = '0;
    expect_out(1, 0, 16'h0, "js_clear_dir");
    expect_out(1, 4, 16'h0, "js_clear_start");
    tick(2);

    send(1'b1, 9'h075);
    expect_out(1, 0, 16'h0, "ps2_up_lat1");
    expect_out(2, 0, 16'h8, "ps2_up");
    tick(3);
    send(1'b0, 9'h175);
    expect_out(1, 0, 16'h8, "ps2_ext_lat1");
    expect_out(2, 0, 16'h0, "ps2_ext_release");
    tick(3);

    send(1'b1, 9'h06B);
    joystick_0 = 16'h0001;
    expect_out(1, 0, 16'h1, "simul_js");
    expect_out(2, 0, 16'h3, "simul_both");
    tick(3);
    send(1'b0, 9'h06B);
    joystick_0 = '0;
    expect_out(1, 0, 16'h2, "simul_rel_js");
    expect_out(2, 0, 16'h0, "simul_rel_kb");
    tick(3);

    send(1'b1, 9'h029);
    expect_out(2, 2, 16'h1, "kb_btn0");
    tick(3);
    send(1'b1, 9'h012);
    expect_out(2, 2, 16'h5, "kb_btn2");
    tick(3);
    send(1'b0, 9'h029);
    expect_out(2, 2, 16'h4, "kb_btn0_rel");
    tick(1);
    send(1'b0, 9'h012);
    expect_out(2, 2, 16'h0, "kb_btn2_rel");
    tick(3);

    joystick_0 = 16'h0008;
    expect_out(1, 0, 16'h8, "rot0");
    tick(2);
    rotate = 2'd1;
    expect_out(1, 0, 16'h1, "rot90");
    tick(2);
    rotate = 2'd2;
    expect_out(1, 0, 16'h4, "rot180");
    tick(2);
    rotate = 2'd3;
    expect_out(1, 0, 16'h2, "rot270");
    tick(2);
    rotate = 2'd0;
    joystick_0 = 16'h000C;
    expect_out(1, 0, 16'hC, "opposing_ud");
    tick(2);
    joystick_0 = '0;
    joystick_1 = 16'h0004;
    rotate = 2'd1;
    expect_out(1, 1, 16'h2, "p2_rot90");
    expect_out(1, 0, 16'h0, "p1_idle");
    tick(2);
    rotate = 2'd0;
    joystick_1 = 16'h0010;
    expect_out(1, 1, 16'h0, "p2_dir_clear");
    expect_out(1, 3, 16'h1, "p2_btn0");
    tick(2);
    joystick_1 = '0;
    expect_out(1, 3, 16'h0, "p2_btn_clear");
    tick(2);

    send(1'b1, 9'h005);
    expect_out(1, 5, 16'h0, "coin_lat1");
    expect_out(2, 4, 16'h1, "kb_start_p1");
    for (int d = 2; d <= 5; d++) expect_out(d, 5, 16'h1, "coin_p1_on");
    expect_out(6, 5, 16'h0, "coin_p1_len");
    tick(1);
    send(1'b1, 9'h02E);
    tick(7);
    send(1'b0, 9'h005);
    expect_out(2, 4, 16'h0, "kb_start_p1_rel");
    tick(1);
    send(1'b0, 9'h02E);
    for (int d = 1; d <= 4; d++) expect_out(d, 5, 16'h0, "coin_no_retrig");
    tick(5);

    send(1'b1, 9'h006);
    expect_out(2, 4, 16'h2, "kb_start_p2");
    for (int d = 2; d <= 4; d++) expect_out(d, 5, 16'h2, "coin_p2_on");
    tick(1);
    ps2_key = {tg, 10'h0};
    tick(3);
    reset_n = 1'b0;
    #1;
    expect_out(-1, 5, 16'h0, "reset_async_coin");
    ->ev_now;
    expect_out(1, 5, 16'h0, "reset_hold_coin");
    expect_out(1, 4, 16'h0, "reset_hold_start");
    tick(2);
    reset_n = 1'b1;
    for (int d = 1; d <= 4; d++) expect_out(d, 5, 16'h0, "post_reset_idle");
    tick(4);
    send(1'b1, 9'h006);
    expect_out(2, 5, 16'h2, "post_reset_edge");
    expect_out(2, 4, 16'h2, "post_reset_start");
    tick(1);
    send(1'b0, 9'h006);
    expect_out(2, 4, 16'h0, "start_p2_rel");
    tick(6);
    expect_out(1, 5, 16'h0, "coin_p2_done");
    tick(2);

    reset_n = 1'b0;
    tick(2);
    reset_n = 1'b1;
    joystick_0 = 16'h0030;
    autofire_en = 3'b001;
    for (int d = 1; d <= 12; d++)
      expect_out(d, 2, (((d - 1) / 3) % 2 == 0) ? 16'h3 : 16'h2, "autofire");
    tick(12);
    autofire_en = 3'b000;
    for (int d = 1; d <= 6; d++) expect_out(d, 2, 16'h3, "autofire_off");
    tick(7);
    joystick_0 = '0;
    expect_out(1, 2, 16'h0, "btn_clear");
    tick(4);

    n_run++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
